// File: rtl/branch_tag_ctrl.sv
// ---------------------------------------------------------------------------
// branch_tag_ctrl
//
// Sequences the Decode->Execute branch-calculation path of the RV32I pipeline.
// Every branch/jump in Decode is given a branch_number tag from a small ring.
// Tags retire in order as Execute resolves them. When all tags are in flight,
// Decode is stalled. A mispredict squashes all younger tags, holds
// fail_predict for FLUSH_CYCLES cycles and emits a one-cycle fetch redirect.
//
// Ports
//   CLK              in   1        clock, rising edge
//   RST              in   1        asynchronous reset, active-high
//   dec_valid        in   1        Decode holds a valid instruction
//   dec_is_branch    in   1        Decode instruction is a branch/jump
//   load_use_hazard  in   1        load-use hazard from the hazard unit
//   res_valid        in   1        Execute resolves a branch this cycle
//   res_tag          in   TAG_W    tag being resolved (branch_numberE)
//   res_mispredict   in   1        resolved branch was mispredicted
//   res_target       in   PC_W     correct next PC of the resolved branch
//   branch_numberD   out  TAG_W    tag for the Decode branch (head pointer)
//   stall            out  1        hold F/D, bubble D/E (combinational)
//   fail_predict     out  1        squash D/E and younger (combinational)
//   redirect_valid   out  1        one-cycle fetch redirect pulse
//   redirect_pc      out  PC_W     redirect target, held between pulses
//   inflight         out  TAG_W+1  number of tags currently allocated
//   err_order        out  1        sticky out-of-order/unallocated resolve
// ---------------------------------------------------------------------------
module branch_tag_ctrl #(
   parameter int unsigned NTAG         = 4,
   parameter int unsigned TAG_W        = 2,
   parameter int unsigned PC_W         = 13,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             dec_valid,
   input  logic             dec_is_branch,
   input  logic             load_use_hazard,
   input  logic             res_valid,
   input  logic [TAG_W-1:0] res_tag,
   input  logic             res_mispredict,
   input  logic [PC_W-1:0]  res_target,
   output logic [TAG_W-1:0] branch_numberD,
   output logic             stall,
   output logic             fail_predict,
   output logic             redirect_valid,
   output logic [PC_W-1:0]  redirect_pc,
   output logic [TAG_W:0]   inflight,
   output logic             err_order
);

   // Flush counter only needs to hold FLUSH_CYCLES-1.
   localparam int unsigned CTR_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   localparam logic [CTR_W-1:0] CTR_INIT   = CTR_W'(FLUSH_CYCLES - 1);
   localparam logic [CTR_W-1:0] CTR_ONE    = CTR_W'(1);
   localparam logic [TAG_W:0]   COUNT_FULL = (TAG_W + 1)'(NTAG);
   localparam logic [TAG_W:0]   COUNT_ONE  = (TAG_W + 1)'(1);
   localparam logic [TAG_W-1:0] TAG_ONE    = TAG_W'(1);

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t           state;
   logic [CTR_W-1:0] flush_ctr;
   logic [TAG_W-1:0] head;
   logic [TAG_W-1:0] tail;
   logic [TAG_W:0]   count;

   logic             in_run;
   logic             mp_evt;
   logic             ok_evt;
   logic             tag_ok;
   logic             full;
   logic             alloc;
   logic             retire;

   // ------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------
   always_comb begin
      in_run = (state == RUN);

      // Resolves are only honoured in RUN; during FLUSH they belong to the
      // squashed path and are ignored.
      mp_evt = in_run & res_valid & res_mispredict;
      ok_evt = in_run & res_valid & ~res_mispredict;

      // A resolve is legal only for the oldest allocated tag.
      tag_ok = (res_tag == tail) && (count != '0);

      // Full is taken from the registered count only, so a resolve in the
      // same cycle does not unblock a waiting allocation.
      full = (count == COUNT_FULL);

      fail_predict = mp_evt | (state == FLUSH);

      // A flush overrides every stall source: the Decode instruction is
      // being squashed anyway.
      stall = ~fail_predict &
              (load_use_hazard | (dec_valid & dec_is_branch & full));

      alloc  = dec_valid & dec_is_branch & ~stall & ~fail_predict;
      retire = ok_evt & tag_ok;

      branch_numberD = head;
      inflight       = count;
   end

   // ------------------------------------------------------------------
   // Tag ring, flush FSM and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state          <= RUN;
         flush_ctr      <= '0;
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         err_order      <= 1'b0;
      end else begin
         redirect_valid <= mp_evt;

         unique case (state)
            RUN: begin
               if (mp_evt) begin
                  // Squash every tag younger than the mispredicted one; the
                  // ring restarts empty just past it.
                  if (!tag_ok) begin
                     err_order <= 1'b1;
                  end
                  head        <= res_tag + TAG_ONE;
                  tail        <= res_tag + TAG_ONE;
                  count       <= '0;
                  redirect_pc <= res_target;
                  if (FLUSH_CYCLES > 1) begin
                     state     <= FLUSH;
                     flush_ctr <= CTR_INIT;
                  end
               end else begin
                  if (ok_evt && !tag_ok) begin
                     err_order <= 1'b1;
                  end
                  if (alloc) begin
                     head <= head + TAG_ONE;
                  end
                  if (retire) begin
                     tail <= tail + TAG_ONE;
                  end
                  // Simultaneous alloc and retire leave the count unchanged.
                  if (alloc && !retire) begin
                     count <= count + COUNT_ONE;
                  end else if (!alloc && retire) begin
                     count <= count - COUNT_ONE;
                  end
               end
            end

            FLUSH: begin
               // The mispredict cycle itself is the first fail_predict
               // cycle, so FLUSH lasts FLUSH_CYCLES-1 cycles.
               if (flush_ctr <= CTR_ONE) begin
                  state     <= RUN;
                  flush_ctr <= '0;
               end else begin
                  flush_ctr <= flush_ctr - CTR_ONE;
               end
            end

            default: begin
               state     <= RUN;
               flush_ctr <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_tag_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_tag_ctrl
//
// Bench for branch_tag_ctrl with NTAG=4, TAG_W=2, PC_W=13, FLUSH_CYCLES=2.
// A table of per-cycle vectors drives the main tag/stall/flush sequences; the
// redirect targets expected from mispredicts are queued and matched against
// redirect pulses. Reset and reset-during-flush are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_branch_tag_ctrl;

   localparam int TAG_W = 2;
   localparam int PC_W  = 13;

   logic             CLK = 1'b0;
   logic             RST;
   logic             dec_valid;
   logic             dec_is_branch;
   logic             load_use_hazard;
   logic             res_valid;
   logic [TAG_W-1:0] res_tag;
   logic             res_mispredict;
   logic [PC_W-1:0]  res_target;
   logic [TAG_W-1:0] branch_numberD;
   logic             stall;
   logic             fail_predict;
   logic             redirect_valid;
   logic [PC_W-1:0]  redirect_pc;
   logic [TAG_W:0]   inflight;
   logic             err_order;

   always #5 CLK = ~CLK;

   branch_tag_ctrl #(
      .NTAG         (4),
      .TAG_W        (TAG_W),
      .PC_W         (PC_W),
      .FLUSH_CYCLES (2)
   ) dut (
      .CLK             (CLK),
      .RST             (RST),
      .dec_valid       (dec_valid),
      .dec_is_branch   (dec_is_branch),
      .load_use_hazard (load_use_hazard),
      .res_valid       (res_valid),
      .res_tag         (res_tag),
      .res_mispredict  (res_mispredict),
      .res_target      (res_target),
      .branch_numberD  (branch_numberD),
      .stall           (stall),
      .fail_predict    (fail_predict),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .inflight        (inflight),
      .err_order       (err_order)
   );

   typedef struct {
      logic             dv;
      logic             br;
      logic             luh;
      logic             rv;
      logic [TAG_W-1:0] tag;
      logic             mp;
      logic [PC_W-1:0]  tgt;
      logic [TAG_W-1:0] e_bn;
      logic             e_stall;
      logic             e_fp;
      logic [TAG_W:0]   e_inf;
      logic             e_rdv;
      logic             e_err;
   } vec_t;

   vec_t            vq[$];
   logic [PC_W-1:0] sb[$];
   int              passed = 0;
   int              total  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Every redirect pulse must match the oldest queued mispredict target.
   task automatic mon_redirect(input string name);
      logic [PC_W-1:0] exp;
      if (redirect_valid === 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            $display("FAIL %s: unexpected redirect pc=0x%0h, none queued", name, redirect_pc);
         end else begin
            exp = sb.pop_front();
            if (redirect_pc === exp) passed++;
            else $display("FAIL %s: redirect_pc got 0x%0h expected 0x%0h", name, redirect_pc, exp);
         end
      end
   endtask

   task automatic add(input logic dv, input logic br, input logic luh, input logic rv,
                      input logic [TAG_W-1:0] tag, input logic mp, input logic [PC_W-1:0] tgt,
                      input logic [TAG_W-1:0] e_bn, input logic e_stall, input logic e_fp,
                      input logic [TAG_W:0] e_inf, input logic e_rdv, input logic e_err);
      vec_t v;
      v.dv = dv; v.br = br; v.luh = luh; v.rv = rv; v.tag = tag; v.mp = mp; v.tgt = tgt;
      v.e_bn = e_bn; v.e_stall = e_stall; v.e_fp = e_fp; v.e_inf = e_inf;
      v.e_rdv = e_rdv; v.e_err = e_err;
      vq.push_back(v);
   endtask

   task automatic drive_idle();
      dec_valid = 0; dec_is_branch = 0; load_use_hazard = 0;
      res_valid = 0; res_tag = '0; res_mispredict = 0; res_target = '0;
   endtask

   initial begin
      //   dv br luh rv tag mp tgt      bn st fp inf rdv err
      // four back-to-back branches, fifth stalls while tag 0 retires
      add(1, 1, 0, 0, 0, 0, 13'h000,  0, 0, 0, 1, 0, 0);
      add(1, 1, 0, 0, 0, 0, 13'h000,  1, 0, 0, 2, 0, 0);
      add(1, 1, 0, 0, 0, 0, 13'h000,  2, 0, 0, 3, 0, 0);
      add(1, 1, 0, 0, 0, 0, 13'h000,  3, 0, 0, 4, 0, 0);
      add(1, 1, 0, 1, 0, 0, 13'h000,  0, 1, 0, 3, 0, 0);
      add(1, 1, 0, 0, 0, 0, 13'h000,  0, 0, 0, 4, 0, 0);
      // drain in order: 1,2,3,0
      add(0, 0, 0, 1, 1, 0, 13'h000,  1, 0, 0, 3, 0, 0);
      add(0, 0, 0, 1, 2, 0, 13'h000,  1, 0, 0, 2, 0, 0);
      add(0, 0, 0, 1, 3, 0, 13'h000,  1, 0, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 13'h000,  1, 0, 0, 0, 0, 0);
      // alloc and retire in the same cycle keep the count
      add(1, 1, 0, 0, 0, 0, 13'h000,  1, 0, 0, 1, 0, 0);
      add(1, 1, 0, 1, 1, 0, 13'h000,  2, 0, 0, 1, 0, 0);
      add(0, 0, 0, 1, 2, 0, 13'h000,  3, 0, 0, 0, 0, 0);
      // tags 3,0,1 in flight; retire 3, mispredict 0
      add(1, 1, 0, 0, 0, 0, 13'h000,  3, 0, 0, 1, 0, 0);
      add(1, 1, 0, 0, 0, 0, 13'h000,  0, 0, 0, 2, 0, 0);
      add(1, 1, 0, 0, 0, 0, 13'h000,  1, 0, 0, 3, 0, 0);
      add(0, 0, 0, 1, 3, 0, 13'h000,  2, 0, 0, 2, 0, 0);
      add(1, 1, 1, 1, 0, 1, 13'h0A4,  2, 0, 1, 0, 1, 0);
      // FLUSH: resolve ignored, no stall, no alloc
      add(1, 1, 1, 1, 1, 1, 13'h155,  1, 0, 1, 0, 0, 0);
      add(1, 1, 0, 0, 0, 0, 13'h000,  1, 0, 0, 1, 0, 0);
      // load-use hazard stalls branch and non-branch alike
      add(1, 0, 1, 0, 0, 0, 13'h000,  2, 1, 0, 1, 0, 0);
      add(1, 1, 1, 0, 0, 0, 13'h000,  2, 1, 0, 1, 0, 0);
      // tags 1,2 in flight; resolving 2 first is an order error
      add(1, 1, 0, 0, 0, 0, 13'h000,  2, 0, 0, 2, 0, 0);
      add(0, 0, 0, 1, 2, 0, 13'h000,  3, 0, 0, 2, 0, 1);
      add(0, 0, 0, 1, 1, 0, 13'h000,  3, 0, 0, 1, 0, 1);

      // ---- reset state ----
      drive_idle();
      RST = 1'b1;
      #3;
      chk("rst_bn", branch_numberD, 0);
      chk("rst_stall", stall, 0);
      chk("rst_fp", fail_predict, 0);
      chk("rst_inflight", inflight, 0);
      chk("rst_rdv", redirect_valid, 0);
      chk("rst_rpc", redirect_pc, 0);
      chk("rst_err", err_order, 0);
      load_use_hazard = 1;
      #1;
      chk("rst_stall_luh", stall, 1);
      load_use_hazard = 0;
      @(negedge CLK);
      RST = 1'b0;

      // ---- table ----
      foreach (vq[i]) begin
         @(negedge CLK);
         dec_valid = vq[i].dv; dec_is_branch = vq[i].br; load_use_hazard = vq[i].luh;
         res_valid = vq[i].rv; res_tag = vq[i].tag; res_mispredict = vq[i].mp;
         res_target = vq[i].tgt;
         if (vq[i].e_rdv) sb.push_back(vq[i].tgt);
         #1;
         chk($sformatf("v%0d_bn", i), branch_numberD, vq[i].e_bn);
         chk($sformatf("v%0d_stall", i), stall, vq[i].e_stall);
         chk($sformatf("v%0d_fp", i), fail_predict, vq[i].e_fp);
         @(posedge CLK);
         #1;
         chk($sformatf("v%0d_inflight", i), inflight, vq[i].e_inf);
         chk($sformatf("v%0d_rdv", i), redirect_valid, vq[i].e_rdv);
         chk($sformatf("v%0d_err", i), err_order, vq[i].e_err);
         mon_redirect($sformatf("v%0d_rpc", i));
      end

      @(negedge CLK);
      drive_idle();
      #1;
      chk("rpc_hold", redirect_pc, 13'h0A4);

      // ---- reset in the second fail_predict cycle ----
      @(negedge CLK);
      res_valid = 1; res_tag = 2; res_mispredict = 1; res_target = 13'h1FF;
      sb.push_back(13'h1FF);
      #1;
      chk("f6_fp1", fail_predict, 1);
      @(posedge CLK);
      #1;
      chk("f6_inflight", inflight, 0);
      chk("f6_rdv", redirect_valid, 1);
      mon_redirect("f6_rpc");
      @(negedge CLK);
      drive_idle();
      #1;
      chk("f6_fp2", fail_predict, 1);
      #2;
      RST = 1'b1;
      #1;
      chk("f6_rst_fp", fail_predict, 0);
      chk("f6_rst_inflight", inflight, 0);
      chk("f6_rst_err", err_order, 0);
      chk("f6_rst_bn", branch_numberD, 0);
      chk("f6_rst_rpc", redirect_pc, 0);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("f6_post_fp", fail_predict, 0);
      @(posedge CLK);
      #1;
      chk("f6_run_fp", fail_predict, 0);
      @(negedge CLK);
      dec_valid = 1; dec_is_branch = 1;
      #1;
      chk("f6_alloc_bn", branch_numberD, 0);
      chk("f6_alloc_stall", stall, 0);
      @(posedge CLK);
      #1;
      chk("f6_alloc_inflight", inflight, 1);
      mon_redirect("f6_tail_rpc");
      @(negedge CLK);
      drive_idle();

      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
